// File: rtl/pci_bus_arbiter.sv
// ============================================================================
// Module  : pci_bus_arbiter
// Brief   : Round-robin PCI arbiter with turnaround and grant timeout.
//           Optional bus parking when PCI_ARB_PARK_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pci_bus_arbiter #(
    parameter int NUM_DEV = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_DEV-1:0] req,
    input  logic               frame,
    input  logic               Iready,
    output logic [NUM_DEV-1:0] grant,
    output logic [2:0]         owner,
    output logic               owner_valid,
    output logic               timeout_pulse
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } state_t;

    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [2:0]         last_q, last_d;
    logic [2:0]         owner_q, owner_d;
    logic [NUM_DEV-1:0] grant_q, grant_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               tpulse_q, tpulse_d;

    logic               w_bus_idle;
    logic [7:0]         w_req_act;
    logic               w_any_req;
    logic [2:0]         w_sel;
    logic [NUM_DEV-1:0] w_sel_grant;

    // z on the open-drain style lines counts as deasserted
    assign w_bus_idle = (frame !== 1'b0) && (Iready !== 1'b0);

    always_comb begin
        w_req_act = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            w_req_act[i] = (req[i] === 1'b0);
        end
    end

    assign w_any_req = |w_req_act;

    // Scan from lowest to highest priority so the nearest requester after
    // last_q wins; with no requester the result falls back to last_q.
    always_comb begin
        int idx;
        w_sel = last_q;
        for (int k = NUM_DEV; k >= 1; k--) begin
            idx = (int'(last_q) + k) % NUM_DEV;
            if (w_req_act[3'(idx)]) begin
                w_sel = 3'(idx);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DEV; i++) begin
            w_sel_grant[i] = (i != int'(w_sel));
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        tpulse_d = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef PCI_ARB_PARK_EN
                if (w_bus_idle) begin
                    if (w_any_req) begin
                        // A park held by someone else must drop for a cycle first
                        if ((&grant_q) || (w_sel == owner_q)) begin
                            grant_d = w_sel_grant;
                            owner_d = w_sel;
                            cnt_d   = 8'd0;
                            state_d = GRANT;
                        end else begin
                            grant_d = '1;
                            owner_d = 3'd0;
                        end
                    end else begin
                        grant_d = w_sel_grant;
                        owner_d = w_sel;
                    end
                end
`else
                grant_d = '1;
                owner_d = 3'd0;
                if (w_bus_idle && w_any_req) begin
                    grant_d = w_sel_grant;
                    owner_d = w_sel;
                    cnt_d   = 8'd0;
                    state_d = GRANT;
                end
`endif
            end
            GRANT: begin
                if (frame === 1'b0) begin
                    state_d = BUSY;
                end else if (!w_req_act[owner_q]) begin
                    grant_d = '1;
                    owner_d = 3'd0;
                    last_d  = owner_q;
                    state_d = IDLE;
                end else if (cnt_q >= c_tmo_last) begin
                    grant_d  = '1;
                    owner_d  = 3'd0;
                    last_d   = owner_q;
                    tpulse_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            BUSY: begin
                if (w_bus_idle) begin
                    grant_d = '1;
                    owner_d = 3'd0;
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '1;
                owner_d = 3'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= 3'(NUM_DEV - 1);
            owner_q  <= 3'd0;
            grant_q  <= '1;
            cnt_q    <= 8'd0;
            tpulse_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            tpulse_q <= tpulse_d;
        end
    end

    assign grant         = grant_q;
    assign owner         = owner_q;
    assign owner_valid   = ~(&grant_q);
    assign timeout_pulse = tpulse_q;

endmodule

`default_nettype wire

// File: doc/pci_bus_arbiter.md
Name: pci_bus_arbiter

Overview:
Central PCI arbiter that sits directly upstream of every PCI device agent on the shared bus.
- Samples each agent's active-low `req` and watches bus activity on `frame` and `Iready`.
- Drives one active-low `grant` per agent using rotating (round-robin) priority.
- Enforces at least one idle turnaround cycle between tenures.
- Revokes a grant that the granted agent never uses.

Parameters:
- NUM_DEV, 4, number of requesting agents (2..8).
- TIMEOUT, 16, cycles a granted agent may take to assert frame before the grant is revoked (2..255).

Ports:
- clock  input  1  bus clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_DEV  active-low requests; bit i belongs to agent i; 1 or z means no request.
- frame  input  1  bus frame line; 0 means asserted, 1 or z means deasserted.
- Iready  input  1  bus initiator-ready line; 0 means asserted, 1 or z means deasserted.
- grant  output  NUM_DEV  active-low grants; at most one bit is 0 at any time.
- owner  output  3  index of the agent currently granted (or parked); 0 when none.
- owner_valid  output  1  1 while grant has a bit at 0.
- timeout_pulse  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Bus idle is defined as `(frame !== 1'b0) && (Iready !== 1'b0)`, evaluated at posedge.
- Reset values:
  - grant = all ones, owner = 0, owner_valid = 0, timeout_pulse = 0.
  - FSM state = IDLE, last_master = NUM_DEV-1, so agent 0 has first priority.
  - Wait counter = 0.
  - Reset asserted mid-transaction releases grant at that same edge; the agent's tenure is simply abandoned.
- FSM states: IDLE, GRANT, BUSY.
- IDLE:
  - If bus is idle and any req bit is 0: select the first requester searching upward from last_master+1, wrapping modulo NUM_DEV.
  - Drive that agent's grant bit to 0, set owner, clear the counter, go to GRANT.
  - Latency: req sampled 0 at edge N makes grant 0 after edge N.
  - If bus is not idle (foreign tenure), stay in IDLE with grant all ones.
- GRANT:
  - frame sampled 0: go to BUSY, grant held.
  - Else if req[owner] sampled 1 (request withdrawn): release grant, last_master <= owner, go to IDLE.
  - Else if counter == TIMEOUT-1: release grant, pulse timeout_pulse for one cycle, last_master <= owner, go to IDLE.
  - Otherwise increment the counter.
- BUSY:
  - Grant stays at 0 while frame or Iready is asserted; the agent's initiator logic relies on it.
  - When bus is idle: release grant (all ones), last_master <= owner, go to IDLE.
- Turnaround:
  - Every transition to IDLE outputs grant all ones for at least one full cycle before any new grant, including back-to-back requests from the same agent.
- Round-robin:
  - The agent that just finished always has lowest priority next round.
  - With a single requester, that agent is re-granted after each turnaround cycle.
- Simultaneous requests: resolved purely by rotation order; there is no fixed priority.
- Ignored req changes:
  - Changes on non-owner req bits during GRANT or BUSY have no effect.
  - Pending requests are evaluated at the next IDLE.
- Counter: 8 bits; saturates at TIMEOUT-1 and never wraps.

Optional Feature:
PCI_ARB_PARK_EN
- When defined, bus parking is enabled: in IDLE with bus idle and no req at 0, grant is parked at 0 on last_master. After reset this is agent NUM_DEV-1, and owner_valid = 1.
- A parked agent that asserts req moves directly to GRANT with no turnaround cycle.
- A request from any other agent first releases the park for one cycle (grant all ones), then grants normally.
- Parking does not run the timeout counter.
- When not defined, grant is all ones whenever no tenure is active.

Test Plan:
- Reset held 2 cycles, req = 4'b1111 -> grant = 4'b1111, owner_valid = 0. With PARK_EN: grant = 4'b0111 after reset release.
- req = 4'b1110 at edge 3, bus idle -> grant = 4'b1110 after edge 3. frame driven 0 at edge 5 -> state BUSY, grant held. frame and Iready return z -> grant = 4'b1111 for exactly one cycle.
- req = 4'b0000 held continuously, each agent runs a 2-cycle tenure -> grant order 0,1,2,3,0, with one all-ones cycle between each.
- req = 4'b1101, frame never asserted -> grant = 4'b1101 for 16 cycles, then timeout_pulse = 1 for one cycle and grant = 4'b1111.
- Agent 2 granted, its req returns to 1 before frame -> grant released next edge, no timeout_pulse. Then req = 4'b1011 -> agent 2 re-granted after one idle cycle.
- Reset asserted while agent 1 is in BUSY with frame = 0 -> grant = 4'b1111 at that edge. After reset release, with frame held 0, no new grant is issued until the bus is idle.
